// File: rtl/acq_done_tracker.sv
// acq_done_tracker: turns per-sensor completion pulses into done levels.
// Watchdog built only when ACQ_DONE_TRACKER_TIMEOUT_EN is defined.
module acq_done_tracker #(
  parameter int N_SENSORS = 10,
  parameter int WAIT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trigger,
  input  logic [N_SENSORS-1:0] en_bits,
  input  logic [N_SENSORS-1:0] done_pulse_in,
  input  logic [WAIT_W-1:0]    timeout_cycles,
  input  logic                 clear_status,
  output logic [N_SENSORS-1:0] done_out,
  output logic                 busy,
  output logic                 timeout_flag,
  output logic [N_SENSORS-1:0] timed_out_mask,
  output logic [7:0]           overrun_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [N_SENSORS-1:0] pend_q;
  logic [N_SENSORS-1:0] pend_d;
  logic [N_SENSORS-1:0] done_q;
  logic [N_SENSORS-1:0] done_d;
  logic [WAIT_W-1:0]    wait_q;
  logic [WAIT_W-1:0]    wait_d;
  logic [N_SENSORS-1:0] remain;
  logic [N_SENSORS-1:0] forced;
  logic [7:0]           ovr_q;
  logic                 in_acq;
  logic                 fire;
  logic                 overrun;

  assign in_acq  = (state_q == S_ACQ);
  assign remain  = pend_q & ~done_pulse_in;
  assign overrun = trigger & in_acq;

`ifdef ACQ_DONE_TRACKER_TIMEOUT_EN
  logic [WAIT_W-1:0] last_cyc;

  assign last_cyc = timeout_cycles - WAIT_W'(1);
  assign fire = in_acq & ~trigger
              & (|timeout_cycles)
              & (wait_q == last_cyc)
              & (|remain);
`else
  logic unused_tmo;

  assign unused_tmo = ^timeout_cycles;
  assign fire       = 1'b0;
`endif

  assign forced = fire ? remain : '0;

  // Next-state: trigger re-arms from any state, ACQUIRE latches pulses
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    done_d  = done_q;
    wait_d  = wait_q;
    if (trigger) begin
      done_d  = '0;
      wait_d  = '0;
      pend_d  = en_bits;
      state_d = (|en_bits) ? S_ACQ : S_IDLE;
    end else if (in_acq) begin
      done_d = done_q
             | (done_pulse_in & pend_q)
             | forced;
      pend_d = fire ? '0 : remain;
      if (!(&wait_q)) begin
        wait_d = wait_q + WAIT_W'(1);
      end
      if (fire || (remain == '0)) begin
        state_d = S_CMP;
      end
    end else if (state_q == 2'd3) begin
      state_d = S_IDLE;
    end
  end

  // Acquisition state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      done_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      wait_q  <= wait_d;
    end
  end

  // Saturating overrun count; a new overrun beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= '0;
    end else if (overrun) begin
      if (clear_status) begin
        ovr_q <= 8'd1;
      end else if (!(&ovr_q)) begin
        ovr_q <= ovr_q + 8'd1;
      end
    end else if (clear_status) begin
      ovr_q <= '0;
    end
  end

`ifdef ACQ_DONE_TRACKER_TIMEOUT_EN
  logic                 tflag_q;
  logic [N_SENSORS-1:0] tmask_q;

  // Sticky timeout status; a new timeout beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tflag_q <= 1'b0;
      tmask_q <= '0;
    end else if (clear_status) begin
      tflag_q <= fire;
      tmask_q <= forced;
    end else begin
      tflag_q <= tflag_q | fire;
      tmask_q <= tmask_q | forced;
    end
  end

  assign timeout_flag   = tflag_q;
  assign timed_out_mask = tmask_q;
`else
  assign timeout_flag   = 1'b0;
  assign timed_out_mask = '0;
`endif

  assign done_out    = done_q;
  assign busy        = in_acq;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_acq_done_tracker.sv
// tb_acq_done_tracker: scoreboard bench for acq_done_tracker.
// Reference model works on completion sets and elapsed time.
module tb_acq_done_tracker;

`ifdef ACQ_DONE_TRACKER_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] done;
    logic       busy;
    logic       tflag;
    logic [9:0] tmask;
    logic [7:0] ovr;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic        clear_status = 1'b0;
  logic [9:0]  en_bits = '0;
  logic [9:0]  done_pulse_in = '0;
  logic [15:0] timeout_cycles = '0;
  logic [9:0]  done_out;
  logic [9:0]  timed_out_mask;
  logic        busy;
  logic        timeout_flag;
  logic [7:0]  overrun_cnt;

  int   n_pass = 0;
  int   n_tot = 0;
  obs_t q[$];

  bit          rst_v = 1'b0;
  logic [15:0] tmo_v = '0;

  int      cyc_n = 0;
  int      t0 = 0;
  int      ovr_m = 0;
  bit      active = 1'b0;
  bit      tflag_m = 1'b0;
  bit [9:0] en_m = '0;
  bit [9:0] comp_m = '0;
  bit [9:0] forced_m = '0;
  bit [9:0] tmask_m = '0;

  always #5 clk = ~clk;

  acq_done_tracker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trigger        (trigger),
    .en_bits        (en_bits),
    .done_pulse_in  (done_pulse_in),
    .timeout_cycles (timeout_cycles),
    .clear_status   (clear_status),
    .done_out       (done_out),
    .busy           (busy),
    .timeout_flag   (timeout_flag),
    .timed_out_mask (timed_out_mask),
    .overrun_cnt    (overrun_cnt)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  nm, act, exp);
  endtask

  // One sampled edge of the reference model
  task automatic model_step(bit rst, bit trg, bit [9:0] en,
                            bit [9:0] pul, bit clr, int t);
    bit [9:0] newto;
    bit       ovr_ev;
    obs_t     e;
    newto = '0;
    if (!rst) begin
      active = 0; en_m = 0; comp_m = 0; forced_m = 0;
      tmask_m = 0; tflag_m = 0; ovr_m = 0;
    end else begin
      ovr_ev = trg && active;
      if (trg) begin
        t0 = cyc_n; en_m = en; comp_m = 0; forced_m = 0;
        active = (en != 0);
      end else if (active) begin
        comp_m |= pul & en_m;
        if (WD && t != 0 && (cyc_n - t0) == t &&
            (en_m & ~comp_m) != 0) begin
          newto = en_m & ~comp_m;
          forced_m = newto;
          active = 0;
        end else if ((en_m & ~comp_m) == 0) begin
          active = 0;
        end
      end
      if (clr) begin
        tmask_m = 0; tflag_m = 0; ovr_m = 0;
      end
      tmask_m |= newto;
      if (newto != 0) tflag_m = 1;
      if (ovr_ev && ovr_m < 255) ovr_m++;
    end
    cyc_n++;
    e = {comp_m | forced_m, active, tflag_m,
         tmask_m, 8'(ovr_m)};
    q.push_back(e);
  endtask

  task automatic cyc(bit trg, bit [9:0] en,
                     bit [9:0] pul, bit clr);
    @(negedge clk);
    rst_n = rst_v;
    trigger = trg;
    en_bits = en;
    done_pulse_in = pul;
    clear_status = clr;
    timeout_cycles = tmo_v;
    model_step(rst_v, trg, en, pul, clr, int'(tmo_v));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: compare every cycle's outputs
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      obs_t e;
      obs_t a;
      e = q.pop_front();
      a = {done_out, busy, timeout_flag,
           timed_out_mask, overrun_cnt};
      n_tot++;
      if (a === e) n_pass++;
      else $display("FAIL sb t=%0t: got d=%h b=%b f=%b m=%h o=%0d want d=%h b=%b f=%b m=%h o=%0d",
                    $time, a.done, a.busy, a.tflag, a.tmask,
                    a.ovr, e.done, e.busy, e.tflag, e.tmask,
                    e.ovr);
    end
  end

  initial begin
    rst_v = 0;
    repeat (3) cyc(0, 0, 0, 0);
    settle();
    chk("rst_done", 32'(done_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovr", 32'(overrun_cnt), 0);
    chk("rst_flag", 32'(timeout_flag), 0);
    rst_v = 1;

    tmo_v = 100;
    cyc(1, 10'h201, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 0, (k == 5) ? 10'h001 :
                (k == 20) ? 10'h200 : 10'h000, 0);
      if (k == 5) begin
        settle();
        chk("norm_done5", 32'(done_out), 32'h001);
        chk("norm_busy5", 32'(busy), 1);
      end
    end
    settle();
    chk("norm_done20", 32'(done_out), 32'h201);
    chk("norm_busy20", 32'(busy), 0);
    chk("norm_flag", 32'(timeout_flag), 0);

    tmo_v = 10;
    cyc(1, 10'h003, 0, 0);
    for (int k = 1; k <= 10; k++)
      cyc(0, 0, (k == 3) ? 10'h001 : 10'h000, 0);
    settle();
    chk("to_done", 32'(done_out), WD ? 32'h3 : 32'h1);
    chk("to_mask", 32'(timed_out_mask), WD ? 32'h2 : 0);
    chk("to_flag", 32'(timeout_flag), 32'(WD));
    chk("to_busy", 32'(busy), 32'(!WD));
    cyc(1, 10'h000, 0, 0);
    settle();
    chk("to_mask_hold", 32'(timed_out_mask), WD ? 32'h2 : 0);
    chk("to_flag_hold", 32'(timeout_flag), 32'(WD));
    chk("to_done_clr", 32'(done_out), 0);
    cyc(0, 0, 0, 1);
    settle();
    chk("clr_mask", 32'(timed_out_mask), 0);
    chk("clr_flag", 32'(timeout_flag), 0);
    chk("clr_ovr", 32'(overrun_cnt), 0);

    tmo_v = 8;
    cyc(1, 10'h010, 0, 0);
    for (int k = 1; k <= 8; k++)
      cyc(0, 0, (k == 8) ? 10'h010 : 10'h000, 0);
    settle();
    chk("sim_done", 32'(done_out), 32'h010);
    chk("sim_mask", 32'(timed_out_mask), 0);
    chk("sim_flag", 32'(timeout_flag), 0);
    chk("sim_busy", 32'(busy), 0);

    tmo_v = 0;
    cyc(1, 10'h0FF, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(1, 10'h0FF, 10'h0FF, 0);
    settle();
    chk("ovr_one", 32'(overrun_cnt), 1);
    chk("ovr_done", 32'(done_out), 0);
    chk("ovr_busy", 32'(busy), 1);
    repeat (299) cyc(1, 10'h0FF, 0, 0);
    settle();
    chk("ovr_sat", 32'(overrun_cnt), 255);
    cyc(1, 10'h0FF, 0, 1);
    settle();
    chk("ovr_clr_set", 32'(overrun_cnt), 1);
    cyc(1, 10'h000, 0, 0);
    settle();
    chk("en0_busy", 32'(busy), 0);
    chk("en0_done", 32'(done_out), 0);
    cyc(0, 0, 10'h3FF, 0);
    settle();
    chk("idle_pulse", 32'(done_out), 0);

    cyc(1, 10'h3FF, 0, 0);
    cyc(0, 0, 10'h005, 0);
    cyc(0, 0, 0, 0);
    settle();
    rst_n = 0;
    rst_v = 0;
    #1;
    chk("arst_done", 32'(done_out), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ovr", 32'(overrun_cnt), 0);
    chk("arst_mask", 32'(timed_out_mask), 0);
    repeat (2) cyc(0, 0, 0, 0);
    rst_v = 1;
    repeat (10) cyc(0, 0, 10'h3FF, 0);
    settle();
    chk("post_rst_done", 32'(done_out), 0);
    chk("post_rst_busy", 32'(busy), 0);

    for (int i = 0; i < 4000; i++) begin
      bit       trg;
      bit       clr;
      bit [9:0] en;
      bit [9:0] pul;
      trg = ($urandom_range(0, 29) == 0);
      en  = ($urandom_range(0, 7) == 0) ? 10'h0
                                        : 10'($urandom);
      pul = 10'($urandom) & 10'($urandom) & 10'($urandom);
      clr = ($urandom_range(0, 99) == 0);
      if (trg)
        tmo_v = ($urandom_range(0, 3) == 0) ? 16'd0
              : 16'($urandom_range(1, 40));
      cyc(trg, en, pul, clr);
    end

    tmo_v = 5;
    cyc(1, 10'h001, 0, 0);
    repeat (1100) cyc(0, 0, 10'h002, 0);
    settle();
    chk("long_busy", 32'(busy), 32'(!WD));
    chk("long_done", 32'(done_out), WD ? 32'h1 : 0);

    cyc(0, 0, 0, 0);
    settle();
    chk("sb_drain", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
